calculate_checksum_reg: RTL and testbench
=========================================

Name: calculate_checksum_reg

Overview:
Registered flit checksum stage for the NoC datapath. It accepts one types::flit_t per handshake and computes the 8-bit checksum over header and payload. It flags whether the incoming checksum field matches, and emits the flit with its checksum field overwritten by the computed value. It sits between flit producers/receivers and the flit queues, one pipeline stage deep with valid/ready flow control.

Parameters:
FLIT_W, $bits(types::flit_t), total packed flit width; must be at least 16.
CSUM_W, 8, checksum width; equals $bits(types::checksum_t).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  flit_in is presented.
in_ready  output  1  stage can accept flit_in this cycle.
flit_in  input  FLIT_W  types::flit_t: header {version, flittype, src_id, dst_id, flit_id{packet_id, flit_num}}, payload, checksum.
out_valid  output  1  registered result is valid.
out_ready  input  1  downstream accepts result.
checksum  output  CSUM_W  computed checksum of the held flit.
is_valid  output  1  1 when flit_in.checksum equals the computed checksum.
flit_out  output  FLIT_W  held flit with checksum field replaced by the computed checksum.

Behaviour:
- Interface: one clock domain on clk; reset rst_n is asynchronous and active-low.
- Checksum field: occupies flit bits [CSUM_W-1:0], the last struct member. The covered data is bits [FLIT_W-1:CSUM_W].
- Zero-padding: covered data is zero-padded at the MSB end to a multiple of 8 bits, then split into bytes.
- Computation: checksum = unsigned sum of all bytes, modulo 256 (carries discarded, no end-around carry).
- Compare: is_valid = (flit_in[CSUM_W-1:0] == computed checksum).
- Output flit: flit_out[FLIT_W-1:CSUM_W] = flit_in[FLIT_W-1:CSUM_W]; flit_out[CSUM_W-1:0] = computed checksum.
- Compute path: purely combinational from flit_in. Results are registered on accept.
- Latency: exactly 1 cycle from accept to out_valid.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready. On the next clk edge, out_valid=1 and checksum/is_valid/flit_out load the new results.
  - If out_valid && out_ready and no accept, out_valid clears next edge.
  - Simultaneous drain and accept: out_valid stays 1 and the outputs update to the new flit. No bubble, full throughput of 1 flit/cycle.
  - While out_valid && !out_ready: in_ready=0, and all outputs hold stable bit-for-bit.
- Data registers: checksum, is_valid and flit_out load only on accept. They are not cleared on drain.
- Reset (async assert, any time, including mid-transfer):
  - out_valid=0, checksum=0, is_valid=0, flit_out=0; any held flit is dropped.
  - in_ready=1 while out_valid=0, including during reset.
- Release: synchronous to the clk domain; the first accept is possible on the first edge after deassertion.
- X-safety: when in_valid=0, flit_in is don't-care and must not affect the registers.

Test Plan:
- All-zero flit, checksum field 0x00, in_valid=1, out_ready=1 -> next cycle out_valid=1, checksum=0x00, is_valid=1, flit_out all zero.
- All-zero header/payload, checksum field 0x02 -> checksum=0x00, is_valid=0, flit_out checksum field 0x00, header/payload zero.
- Covered bytes 0xFF and 0x02, others 0, checksum field 0x01 -> checksum=0x01 (wrap-around), is_valid=1. Same flit with field 0x00 -> is_valid=0.
- Back-to-back flits A,B,C with out_ready=1 -> out_valid continuous, results in order, one per cycle, in_ready constantly 1.
- Hold out_ready=0 for 3 cycles after accepting A:
  - in_ready=0 and outputs stable for those 3 cycles.
  - B is held off at the input.
  - After out_ready=1, A drains and B is accepted in the same cycle.
- Assert rst_n=0 mid-cycle while out_valid=1 -> out_valid, checksum, is_valid, flit_out go to 0 immediately without a clock edge; in_ready=1.

Source files
------------

// File: rtl/calculate_checksum_reg.sv
// -----------------------------------------------------------------------------
// calculate_checksum_reg
//
// Registered flit checksum stage for the NoC datapath. Each accepted flit goes
// through the same steps:
//   - An 8-bit additive checksum is computed over the covered part of the flit
//     (header + payload, everything above the checksum field).
//   - The incoming checksum field is compared against the computed value.
//   - The flit is re-emitted with its checksum field replaced by the computed
//     value.
// The stage is one pipeline register deep and uses valid/ready flow control.
// It sustains one flit per cycle when downstream is ready.
//
// Flit layout (MSB .. LSB), default FLIT_W = 70:
//   version[3:0], flittype[1:0], src_id[5:0], dst_id[5:0],
//   flit_id{packet_id[7:0], flit_num[3:0]}, payload[31:0], checksum[7:0]
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   flit_in is presented
//   in_ready   out  stage can accept flit_in this cycle
//   flit_in    in   incoming flit (FLIT_W bits)
//   out_valid  out  registered result is valid
//   out_ready  in   downstream accepts the result
//   checksum   out  computed checksum of the held flit
//   is_valid   out  incoming checksum field matched the computed checksum
//   flit_out   out  held flit with checksum field replaced by computed value
// -----------------------------------------------------------------------------
module calculate_checksum_reg #(
    parameter int FLIT_W = 70,
    parameter int CSUM_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] flit_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CSUM_W-1:0] checksum,
    output logic              is_valid,
    output logic [FLIT_W-1:0] flit_out
);

    // The covered region is zero-padded at the MSB end up to a whole number
    // of bytes.
    localparam int COV_W  = FLIT_W - CSUM_W;
    localparam int NBYTES = (COV_W + 7) / 8;
    localparam int PAD_W  = NBYTES * 8;

    // Byte-wise sum modulo 2**CSUM_W. Carries out of the accumulator are
    // dropped; there is no end-around carry.
    function automatic logic [CSUM_W-1:0] calc_csum(input logic [FLIT_W-1:0] f);
        logic [PAD_W-1:0]  cov;
        logic [CSUM_W-1:0] acc;
        cov = PAD_W'(f[FLIT_W-1:CSUM_W]);
        acc = '0;
        for (int i = 0; i < NBYTES; i++) begin
            acc = acc + CSUM_W'(cov[i*8 +: 8]);
        end
        return acc;
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [CSUM_W-1:0] checksum_q,  checksum_d;
    logic              is_valid_q,  is_valid_d;
    logic [FLIT_W-1:0] flit_out_q,  flit_out_d;

    logic              accept;
    logic [CSUM_W-1:0] csum_calc;

    // Combinational compute path, stage input side
    assign csum_calc = calc_csum(flit_in);

    // A slot is free when nothing is held or the held result drains this cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        checksum_d  = checksum_q;
        is_valid_d  = is_valid_q;
        flit_out_d  = flit_out_q;

        if (accept) begin
            // An accept overrides a simultaneous drain, so there is no bubble.
            out_valid_d = 1'b1;
            checksum_d  = csum_calc;
            is_valid_d  = (flit_in[CSUM_W-1:0] == csum_calc);
            flit_out_d  = {flit_in[FLIT_W-1:CSUM_W], csum_calc};
        end else if (out_ready) begin
            // Data registers keep their contents on drain; only valid drops.
            out_valid_d = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
            is_valid_q  <= 1'b0;
            flit_out_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            checksum_q  <= checksum_d;
            is_valid_q  <= is_valid_d;
            flit_out_q  <= flit_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign checksum  = checksum_q;
    assign is_valid  = is_valid_q;
    assign flit_out  = flit_out_q;

endmodule

// File: tb/tb_calculate_checksum_reg.sv
module tb_calculate_checksum_reg;

    localparam int FLIT_W = 70;
    localparam int CSUM_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] flit_in;
    logic              out_valid;
    logic              out_ready;
    logic [CSUM_W-1:0] checksum;
    logic              is_valid;
    logic [FLIT_W-1:0] flit_out;

    calculate_checksum_reg #(.FLIT_W(FLIT_W), .CSUM_W(CSUM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flit_in   (flit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .checksum  (checksum),
        .is_valid  (is_valid),
        .flit_out  (flit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CSUM_W-1:0] cs;
        logic              iv;
        logic [FLIT_W-1:0] fo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: treat the covered region as one big unsigned number and peel
    // off base-256 digits; the high zero digits are the implicit padding.
    function automatic logic [CSUM_W-1:0] ref_csum(input logic [FLIT_W-1:0] f);
        logic [FLIT_W-1:0] v;
        int unsigned       s;
        v = f >> CSUM_W;
        s = 0;
        while (v != 0) begin
            s += int'(v % 256);
            v = v / 256;
        end
        return CSUM_W'(s % 256);
    endfunction

    function automatic exp_t ref_result(input logic [FLIT_W-1:0] f);
        exp_t e;
        e.cs = ref_csum(f);
        e.iv = (f[CSUM_W-1:0] == e.cs);
        e.fo = {f[FLIT_W-1:CSUM_W], e.cs};
        return e;
    endfunction

    function automatic logic [FLIT_W-1:0] rand_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[FLIT_W-1:0];
    endfunction

    // One cycle of stimulus; called just after a rising edge.
    task automatic drive(input logic v, input logic [FLIT_W-1:0] f, input logic ordy);
        logic exp_rdy;
        in_valid  = v;
        flit_in   = f;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (q.size() == 0) || ordy;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clk);
        if (v && exp_rdy) q.push_back(ref_result(f));
        #1;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    initial begin
        logic do_pop;
        forever begin
            @(negedge clk);
            do_pop = 1'b0;
            if (rst_n) begin
                check("out_valid", 128'(out_valid), 128'(q.size() != 0));
                if (out_valid && q.size() != 0) begin
                    check("checksum", 128'(checksum), 128'(q[0].cs));
                    check("is_valid", 128'(is_valid), 128'(q[0].iv));
                    check("flit_out", 128'(flit_out), 128'(q[0].fo));
                    do_pop = out_ready;
                end
            end
            @(posedge clk);
            if (do_pop && rst_n && q.size() != 0) void'(q.pop_front());
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_checksum"},  128'(checksum),  128'(0));
        check({tag, "_is_valid"},  128'(is_valid),  128'(0));
        check({tag, "_flit_out"},  128'(flit_out),  128'(0));
        check({tag, "_in_ready"},  128'(in_ready),  128'(1));
    endtask

    // Holds reset for two edges, then releases just after an edge so the
    // next edge is the first one after deassertion.
    task automatic hold_and_release();
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    logic [FLIT_W-1:0] f_a, f_b, f_c, wrap_f;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flit_in   = '0;
        out_ready = 1'b0;
        #3;
        check_reset_state("por");
        hold_and_release();

        // Directed cases
        drive(1'b1, '0, 1'b1);
        drive(1'b1, FLIT_W'(8'h02), 1'b1);
        wrap_f = '0;
        wrap_f[15:8]  = 8'hFF;
        wrap_f[23:16] = 8'h02;
        wrap_f[7:0]   = 8'h01;
        drive(1'b1, wrap_f, 1'b1);
        wrap_f[7:0]   = 8'h00;
        drive(1'b1, wrap_f, 1'b1);
        // Top covered bits set: exercises the partially padded MSB byte
        drive(1'b1, {6'h3F, 56'h0, 8'h00}, 1'b1);

        // Back-to-back
        f_a = rand_flit(); f_b = rand_flit(); f_c = rand_flit();
        drive(1'b1, f_a, 1'b1);
        drive(1'b1, f_b, 1'b1);
        drive(1'b1, f_c, 1'b1);
        drive(1'b0, rand_flit(), 1'b1);

        // Stall: A held for 3 cycles, B held off, then drain+accept together
        f_a = rand_flit(); f_b = rand_flit();
        drive(1'b1, f_a, 1'b0);
        repeat (3) drive(1'b1, f_b, 1'b0);
        drive(1'b1, f_b, 1'b1);
        drive(1'b0, rand_flit(), 1'b1);

        // Randomized traffic, roughly half with a correct checksum field
        for (int i = 0; i < 300; i++) begin
            logic [FLIT_W-1:0] f;
            f = rand_flit();
            if ($urandom_range(1, 0) == 1) f[CSUM_W-1:0] = ref_csum(f);
            drive(($urandom_range(9, 0) < 7), f, ($urandom_range(9, 0) < 7));
        end

        // Mid-cycle asynchronous reset while a result is held
        drive(1'b0, rand_flit(), 1'b1);
        drive(1'b1, rand_flit(), 1'b0);
        drive(1'b0, rand_flit(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        q.delete();
        hold_and_release();

        // Immediate accept after release, then more traffic
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(9, 0) < 8), rand_flit(), ($urandom_range(9, 0) < 6));
        end
        repeat (4) drive(1'b0, rand_flit(), 1'b1);
        check("leftover", 128'(q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
